int_ctrl: RTL and testbench

- 16-line interrupt controller; the responder on the core's interrupt interface.
- Latches rising edges on external IRQ lines and masks them with a core-writable enable register.
- Presents the highest-priority request to the core on INT2COR/NUM_INT.
- Runs an acknowledge / end-of-interrupt handshake so that only one interrupt is in service at a time.

---
 rtl/int_ctrl.sv | 156 +++++++++++++++
 tb/tb_int_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: 16-line interrupt controller that responds on the core's interrupt interface.
// Rising edges on IRQ are latched into a pending register and gated by a core-writable mask.
// The highest-priority request (lowest index) is presented on INT2COR/NUM_INT.
// An acknowledge / end-of-interrupt handshake keeps at most one interrupt in service at a time.
// Optional build macro INT_CTRL_SYNC_EN inserts a 2-flop synchronizer in front of the
// edge detector. This adds two edges of IRQ-to-INT2COR latency.
// DATA_W must be at least 16. N_IRQ stays at 16 because NUM_INT is four bits wide.
module int_ctrl #(
  parameter int DATA_W = 16,
  parameter int N_IRQ  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_IRQ-1:0]  IRQ,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              INT_WR,
  input  logic              INT_RD,
  input  logic              INT_EOI,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [3:0]        NUM_INT,
  output logic              INT2COR
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [3:0]         r_numInt;
  logic [3:0]         w_numIntNext;
  logic [N_IRQ-1:0]   r_pending;
  logic [N_IRQ-1:0]   r_mask;
  logic [N_IRQ-1:0]   w_irqNew;
  logic [N_IRQ-1:0]   w_active;
  logic [N_IRQ-1:0]   w_ackMask;
  logic [3:0]         w_prioIdx;
  logic               w_anyActive;
  logic               w_ackClr;

`ifdef INT_CTRL_SYNC_EN
  logic [N_IRQ-1:0]   r_sync1;
  logic [N_IRQ-1:0]   r_sync2;
  logic [N_IRQ-1:0]   r_sync3;

  // Two synchronizer stages, plus a third stage that holds the previous synchronized value.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= IRQ;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_irqNew = r_sync2 & ~r_sync3;
`else
  logic [N_IRQ-1:0]   r_irqQ;

  // Keep the previous IRQ sample so only a low-to-high transition counts as a new request.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_irqQ <= '0;
    end else begin
      r_irqQ <= IRQ;
    end
  end

  assign w_irqNew = IRQ & ~r_irqQ;
`endif

  // Only unmasked pending lines compete. Masked edges wait in pending until they are enabled.
  assign w_active    = r_pending & r_mask;
  assign w_anyActive = |w_active;
  assign w_ackMask   = w_ackClr ? (N_IRQ'(1) << r_numInt) : '0;

  // Mask register. A write takes effect for the IDLE decision one cycle later.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_mask <= '0;
    end else if (INT_WR) begin
      r_mask <= DATA_IN[N_IRQ-1:0];
    end
  end

  // Pending bits. A fresh edge in the same cycle as the acknowledge clear wins, so the bit stays set.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_ackMask) | w_irqNew;
    end
  end

  // Priority encoder. Scanning downward lets the lowest set index overwrite the others.
  always_comb begin
    w_prioIdx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_prioIdx = 4'(i);
      end
    end
  end

  // State and interrupt-number registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_numInt <= 4'd0;
    end else begin
      r_state  <= w_stateNext;
      r_numInt <= w_numIntNext;
    end
  end

  // Handshake FSM. Once a request is presented it is held until the core reads it.
  // Mask changes during REQ therefore never withdraw the request.
  always_comb begin
    w_stateNext  = r_state;
    w_numIntNext = r_numInt;
    w_ackClr     = 1'b0;
    INT2COR      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyActive) begin
          w_stateNext  = ST_REQ;
          w_numIntNext = w_prioIdx;
        end
      end
      ST_REQ: begin
        INT2COR = 1'b1;
        if (INT_RD) begin
          w_ackClr    = 1'b1;
          w_stateNext = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (INT_EOI) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  assign NUM_INT  = r_numInt;
  assign DATA_OUT = INT_RD ? {{(DATA_W-4){1'b0}}, r_numInt} : {DATA_W{1'bz}};

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl in the default build (synchronizer disabled).
module tb_int_ctrl;

  typedef struct {
    logic        rst;
    logic [15:0] irq;
    logic [15:0] din;
    logic        wr;
    logic        rd;
    logic        eoi;
    logic        expInt;
    logic [3:0]  expNum;
    logic [15:0] expOut;
  } vec_t;

  logic        clk;
  logic        resetN;
  logic [15:0] irq;
  logic [15:0] dataIn;
  logic        intWr;
  logic        intRd;
  logic        intEoi;
  wire  [15:0] dataOut;
  logic [3:0]  numInt;
  logic        int2Cor;

  int vecCount  = 0;
  int missCount = 0;
  int reqCount  = 0;
  vec_t vecs[$];

  int_ctrl #(.DATA_W(16), .N_IRQ(16)) dut (
    .CLK      (clk),
    .RESET    (resetN),
    .IRQ      (irq),
    .DATA_IN  (dataIn),
    .INT_WR   (intWr),
    .INT_RD   (intRd),
    .INT_EOI  (intEoi),
    .DATA_OUT (dataOut),
    .NUM_INT  (numInt),
    .INT2COR  (int2Cor)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rst, logic [15:0] irqV, logic [15:0] din, logic wr,
                              logic rd, logic eoi, logic expInt, logic [3:0] expNum,
                              logic [15:0] expOut);
    vec_t v;
    v.rst = rst; v.irq = irqV; v.din = din; v.wr = wr; v.rd = rd; v.eoi = eoi;
    v.expInt = expInt; v.expNum = expNum; v.expOut = expOut;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge so they are stable at the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    resetN = v.rst;
    irq    = v.irq;
    dataIn = v.din;
    intWr  = v.wr;
    intRd  = v.rd;
    intEoi = v.eoi;
  endtask

  // Sample just after the rising edge. DATA_OUT is compared only while the read strobe is held.
  task automatic checkOutput(input vec_t v, input string name);
    @(posedge clk);
    #1;
    vecCount++;
    if (int2Cor) reqCount++;
    if (int2Cor !== v.expInt) begin
      missCount++;
      $display("[TB] FAIL %s INT2COR got %b expected %b", name, int2Cor, v.expInt);
    end
    if (numInt !== v.expNum) begin
      missCount++;
      $display("[TB] FAIL %s NUM_INT got %0d expected %0d", name, numInt, v.expNum);
    end
    if (v.rd && (dataOut !== v.expOut)) begin
      missCount++;
      $display("[TB] FAIL %s DATA_OUT got %h expected %h", name, dataOut, v.expOut);
    end
  endtask

  task automatic step(input logic rst, input logic [15:0] irqV, input logic [15:0] din,
                      input logic wr, input logic rd, input logic eoi, input logic expInt,
                      input logic [3:0] expNum, input logic [15:0] expOut, input string name);
    vec_t v;
    v = mk(rst, irqV, din, wr, rd, eoi, expInt, expNum, expOut);
    applyStimulus(v);
    checkOutput(v, name);
  endtask

  initial begin
    resetN = 1'b0; irq = '0; dataIn = '0; intWr = 1'b0; intRd = 1'b0; intEoi = 1'b0;

    //                rst irq      din      wr rd eoi int num out
    // Reset, then a single IRQ[5] pulse through the full handshake.
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 4'd0, 16'h0000));
    vecs.push_back(mk(1, 16'h0020, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd5, 16'h0005));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd5, 16'h0000));
    // Masked IRQ[3] waits in pending and fires once the mask is opened.
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 1, 0, 0, 0, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0008, 16'h0000, 0, 0, 0, 0, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0008, 1, 0, 0, 0, 4'd5, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd3, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd3, 16'h0003));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd3, 16'h0000));
    // A read in IDLE still drives the number but acknowledges nothing.
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd3, 16'h0003));
    vecs.push_back(mk(1, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 4'd3, 16'h0000));
    // IRQ[2] and IRQ[9] together: 2 wins first, then 9 follows after EOI.
    vecs.push_back(mk(1, 16'h0204, 16'h0000, 0, 0, 0, 0, 4'd3, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd2, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd2, 16'h0002));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd2, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd9, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd9, 16'h0009));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd9, 16'h0000));
    // IRQ[1] arrives while IRQ[4] is in service and waits for EOI; a later EOI in IDLE is ignored.
    vecs.push_back(mk(1, 16'h0010, 16'h0000, 0, 0, 0, 0, 4'd9, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd4, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd4, 16'h0004));
    vecs.push_back(mk(1, 16'h0002, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd4, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd4, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd1, 16'h0001));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd1, 16'h0000));
    vecs.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd1, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // IRQ[7] held high for 20 cycles must produce exactly one request.
    reqCount = 0;
    step(1, 16'h0080, 16'h0000, 0, 0, 0, 0, 4'd1, 16'h0000, "lvl_edge");
    step(1, 16'h0080, 16'h0000, 0, 0, 0, 1, 4'd7, 16'h0000, "lvl_req");
    step(1, 16'h0080, 16'h0000, 0, 1, 0, 0, 4'd7, 16'h0007, "lvl_ack");
    step(1, 16'h0080, 16'h0000, 0, 0, 1, 0, 4'd7, 16'h0000, "lvl_eoi");
    for (int i = 0; i < 16; i++) begin
      step(1, 16'h0080, 16'h0000, 0, 0, 0, 0, 4'd7, 16'h0000, $sformatf("lvl_hold%0d", i));
    end
    vecCount++;
    if (reqCount != 1) begin
      missCount++;
      $display("[TB] FAIL lvl_count requests got %0d expected 1", reqCount);
    end
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd7, 16'h0000, "lvl_drop");

    // The IDLE decision uses the old mask, and mask writes in REQ do not withdraw the request.
    // A reset in REQ then clears everything, including pending.
    step(1, 16'h0040, 16'h0000, 0, 0, 0, 0, 4'd7, 16'h0000, "rq_edge");
    step(1, 16'h0000, 16'h0000, 1, 0, 0, 1, 4'd6, 16'h0000, "rq_oldmask");
    step(1, 16'h0000, 16'h0001, 1, 0, 0, 1, 4'd6, 16'h0000, "rq_maskwr");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd6, 16'h0000, "rq_hold");
    step(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000, "rst_req");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000, "rst_idle");
    step(1, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 4'd0, 16'h0000, "rst_mask");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000, "rst_lost1");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000, "rst_lost2");

    // A new edge on the line being acknowledged keeps it pending.
    // The mask write issued with the read also takes effect.
    step(1, 16'h1000, 16'h0000, 0, 0, 0, 0, 4'd0, 16'h0000, "sim_edge");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd12, 16'h0000, "sim_req");
    step(1, 16'h1000, 16'h0000, 1, 1, 0, 0, 4'd12, 16'h000C, "sim_ackset");
    step(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 4'd12, 16'h0000, "sim_eoi");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd12, 16'h0000, "sim_masked");
    step(1, 16'h0000, 16'h1000, 1, 0, 0, 0, 4'd12, 16'h0000, "sim_unmask");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 1, 4'd12, 16'h0000, "sim_rereq");
    step(1, 16'h0000, 16'h0000, 0, 1, 0, 0, 4'd12, 16'h000C, "sim_ack2");
    step(1, 16'h0000, 16'hFFFF, 1, 0, 1, 0, 4'd12, 16'h0000, "sim_eoiwr");
    step(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 4'd12, 16'h0000, "sim_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
